booth_mul_seq: RTL and testbench

Parametrised, multi-cycle radix-2 Booth multiplier that retires one multiplier bit per clock behind a start/busy/done handshake. It is the sequential successor to the combinational 32×32 Booth unit and sits beside the ALU as the MUL engine. The control unit launches it and stalls until `done`. Unlike the combinational unit, it is correct for the most-negative multiplicand and can optionally multiply unsigned operands.

---
 rtl/booth_mul_seq.sv | 78 +++++++
 tb/tb_booth_mul_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, one bit per clock; BOOTH_MUL_SEQ_UNSIGNED_EN adds the uns port and a WIDTH+1 datapath
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
`ifdef BOOTH_MUL_SEQ_UNSIGNED_EN
  input  logic                 uns,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
`ifdef BOOTH_MUL_SEQ_UNSIGNED_EN
  localparam int E = WIDTH + 1;
  logic [E-1:0] m_ext, q_ext;
  assign m_ext = {~uns & mcand[WIDTH-1], mcand};
  assign q_ext = {~uns & mplier[WIDTH-1], mplier};
`else
  localparam int E = WIDTH;
  logic [E-1:0] m_ext, q_ext;
  assign m_ext = mcand;
  assign q_ext = mplier;
`endif
  localparam int CW = $clog2(E);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]    state;
  logic [E:0]    a, m, sum, new_a;
  logic [E-1:0]  q, new_q;
  logic          q_m1;
  logic [CW-1:0] cnt;
  always_comb begin
    sum   = ({q[0], q_m1} == 2'b01) ? a + m : ({q[0], q_m1} == 2'b10) ? a - m : a;
    new_a = {sum[E], sum[E:1]};
    new_q = {sum[0], q[E-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          a     <= '0;
          m     <= {m_ext[E-1], m_ext};
          q     <= q_ext;
          q_m1  <= 1'b0;
          cnt   <= '0;
        end
      end else begin
        a    <= new_a;
        q    <= new_q;
        q_m1 <= q[0];
        cnt  <= cnt + 1'b1;
        if (cnt == CW'(E - 1)) begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          product <= {new_a[2*WIDTH-E-1:0], new_q};
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq against a cycle-level reference model
module tb_booth_mul_seq;
  localparam int W = 32;
`ifdef BOOTH_MUL_SEQ_UNSIGNED_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, uns = 1'b0;
  logic [W-1:0] mcand = '0, mplier = '0;
  logic busy, done;
  logic [2*W-1:0] product;
  int vectors = 0, errors = 0;
  logic chk_en = 1'b0, prev_done = 1'b0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_prod = '0, m_pend = '0;
  int m_rem = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mcand(mcand),
    .mplier(mplier),
`ifdef BOOTH_MUL_SEQ_UNSIGNED_EN
    .uns(uns),
`endif
    .busy(busy),
    .done(done),
    .product(product)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic u);
    logic [63:0] xe, ye;
    xe = u ? {32'b0, x} : {{32{x[31]}}, x};
    ye = u ? {32'b0, y} : {{32{y[31]}}, y};
    return xe * ye;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: accept in idle, result appears N edges later, reset clears everything
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_rem  <= N;
          m_pend <= ref_mul(mcand, mplier, uns);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_prod <= m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("product", product, m_prod);
      chk("done_twice", 64'(prev_done & done), 64'd0);
      prev_done = done;
    end
  end

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic u);
    mcand = x;
    mplier = y;
    uns = u;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mcand = $urandom;
    mplier = $urandom;
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [63:0] lit);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < lat + 5);
    chk({nm, "_latency"}, 64'(i), 64'(lat));
    chk({nm, "_result"}, product, lit);
    chk({nm, "_model"}, m_prod, lit);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x, y;
    logic u;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(32'd7, 32'hFFFFFFFD, 1'b0);
    wait_done("basic", N, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    launch(32'h80000000, 32'h80000000, 1'b0);
    wait_done("minmin", N, 64'h40000000_00000000);
    launch(32'h80000000, 32'd1, 1'b0);
    wait_done("minone", N, 64'hFFFFFFFF_80000000);
`ifdef BOOTH_MUL_SEQ_UNSIGNED_EN
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done("uns_max", N, 64'hFFFFFFFE_00000001);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done("sgn_m1", N, 64'h00000000_00000001);
`endif
    @(negedge clk);
    launch(32'd5, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    mcand = 32'd9;
    mplier = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", N - 6, 64'd30);
    launch(32'd9, 32'd9, 1'b0);
    wait_done("back2back", N, 64'd81);
    @(negedge clk);
    launch(32'd12345, 32'hFFFFFD5A, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", product, 64'd0);
    repeat (N + 2) @(negedge clk);
    chk("abort_nodone_product", product, 64'd0);
    launch(32'd3, 32'd4, 1'b0);
    wait_done("after_abort", N, 64'd12);
    for (int k = 0; k < 250; k++) begin
      x = (k % 17 == 0) ? 32'h80000000 : $urandom;
      y = (k % 13 == 0) ? 32'h80000000 : $urandom;
`ifdef BOOTH_MUL_SEQ_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
`else
      u = 1'b0;
`endif
      if (k % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      launch(x, y, u);
      wait_done("random", N, ref_mul(x, y, u));
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
